// File: rtl/memory_arbiter_n.sv
// rtl/memory_arbiter_n.sv - round-robin memory arbiter with snoop and cache-to-cache transfer for N cache pairs
module memory_arbiter_n #(
    parameter int CPUS     = 2,
    parameter int BLKWORDS = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [CPUS-1:0]       iREN,
    input  logic [CPUS-1:0]       dREN,
    input  logic [CPUS-1:0]       dWEN,
    input  logic [CPUS-1:0]       ccwrite,
    input  logic [CPUS-1:0]       cctrans,
    input  logic [CPUS-1:0][31:0] iaddr,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    output logic [CPUS-1:0]       iwait,
    output logic [CPUS-1:0]       dwait,
    output logic [CPUS-1:0]       ccwait,
    output logic [CPUS-1:0]       ccinv,
    output logic [CPUS-1:0][31:0] iload,
    output logic [CPUS-1:0][31:0] dload,
    output logic [CPUS-1:0][31:0] ccsnoopaddr,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  logic [1:0]            ramstate
);
    localparam int IW = $clog2(CPUS);
    localparam int WW = (BLKWORDS > 1) ? $clog2(BLKWORDS) : 1;
    // RAM handshake encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3
    localparam logic [1:0]    RAM_ACCESS = 2'b10;
    localparam logic [WW-1:0] LAST_WORD  = WW'(BLKWORDS - 1);

    typedef enum logic [2:0] {IDLE, ARB, SNOOP, LD, CL, WB, IF} state_t;

    state_t        state, state_n;
    logic [IW-1:0] req, req_n;
    logic [IW-1:0] src, src_n;
    logic [IW-1:0] dptr, dptr_n;
    logic [IW-1:0] iptr, iptr_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic          access;
    logic [IW:0]   c_pick, d_pick, i_pick, s_pick;

    // First requester at or after ptr, wrapping; MSB flags that one was found.
    // CPUS is a power of two, so the IW-bit add wraps modulo CPUS.
    function automatic logic [IW:0] rr_pick(input logic [CPUS-1:0] r, input logic [IW-1:0] ptr);
        logic [IW:0]   pick;
        logic [IW-1:0] idx;
        pick = '0;
        for (int i = CPUS - 1; i >= 0; i--) begin
            idx = ptr + IW'(i);
            if (r[idx]) pick = {1'b1, idx};
        end
        return pick;
    endfunction

    // Lowest-index cache other than the requester that answers the snoop
    function automatic logic [IW:0] supplier(input logic [CPUS-1:0] r, input logic [IW-1:0] who);
        logic [IW:0] pick;
        pick = '0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            if (r[k] && (IW'(k) != who)) pick = {1'b1, IW'(k)};
        end
        return pick;
    endfunction

    assign access = (ramstate == RAM_ACCESS);
    assign c_pick = rr_pick(cctrans, dptr);
    assign d_pick = rr_pick(dWEN, dptr);
    assign i_pick = rr_pick(iREN, iptr);
    assign s_pick = supplier(cctrans, req);

    // State, grant, pointer and word-count registers; reset abandons any transfer
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            req   <= '0;
            src   <= '0;
            dptr  <= '0;
            iptr  <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_n;
            req   <= req_n;
            src   <= src_n;
            dptr  <= dptr_n;
            iptr  <= iptr_n;
            wcnt  <= wcnt_n;
        end
    end

    // Next-state selection and per-state steering of cache and RAM signals
    always_comb begin
        state_n     = state;
        req_n       = req;
        src_n       = src;
        dptr_n      = dptr;
        iptr_n      = iptr;
        wcnt_n      = wcnt;
        iwait       = '1;
        dwait       = '1;
        ccwait      = '0;
        ccinv       = '0;
        iload       = '0;
        dload       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (state)
            IDLE: begin
                if (c_pick[IW]) begin
                    req_n   = c_pick[IW-1:0];
                    state_n = ARB;
                end else if (d_pick[IW]) begin
                    req_n   = d_pick[IW-1:0];
                    wcnt_n  = '0;
                    state_n = WB;
                end else if (i_pick[IW]) begin
                    req_n   = i_pick[IW-1:0];
                    state_n = IF;
                end
            end
            ARB: begin
                state_n = dREN[req] ? SNOOP : IDLE;
            end
            SNOOP: begin
                for (int k = 0; k < CPUS; k++) begin
                    if (IW'(k) != req) begin
                        ccwait[k]      = 1'b1;
                        ccsnoopaddr[k] = daddr[req];
                        ccinv[k]       = ccwrite[req];
                    end
                end
                wcnt_n = '0;
                if (s_pick[IW]) begin
                    src_n   = s_pick[IW-1:0];
                    state_n = CL;
                end else begin
                    state_n = LD;
                end
            end
            LD: begin
                ramREN      = 1'b1;
                ramaddr     = daddr[req];
                dload[req]  = ramload;
                ccwait      = '1;
                ccwait[req] = 1'b0;
                if (access) begin
                    dwait[req] = 1'b0;
                    wcnt_n     = wcnt + WW'(1);
                    if (wcnt == LAST_WORD) begin
                        state_n = IDLE;
                        dptr_n  = req + IW'(1);
                    end
                end
            end
            CL: begin
                dload[req]  = dstore[src];
                ramWEN      = 1'b1;
                ramaddr     = daddr[src];
                ramstore    = dstore[src];
                ccwait[src] = 1'b1;
                if (access) begin
                    dwait[req] = 1'b0;
                    dwait[src] = 1'b0;
                    wcnt_n     = wcnt + WW'(1);
                    if (wcnt == LAST_WORD) begin
                        state_n = IDLE;
                        dptr_n  = req + IW'(1);
                    end
                end
            end
            WB: begin
                ramWEN      = 1'b1;
                ramaddr     = daddr[req];
                ramstore    = dstore[req];
                ccwait      = '1;
                ccwait[req] = 1'b0;
                if (access) begin
                    dwait[req] = 1'b0;
                    wcnt_n     = wcnt + WW'(1);
                    if (wcnt == LAST_WORD) begin
                        state_n = IDLE;
                        dptr_n  = req + IW'(1);
                    end
                end
            end
            IF: begin
                ramREN     = 1'b1;
                ramaddr    = iaddr[req];
                iload[req] = ramload;
                if (access) begin
                    iwait[req] = 1'b0;
                    state_n    = IDLE;
                    iptr_n     = req + IW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_memory_arbiter_n.sv
// tb/tb_memory_arbiter_n.sv - transaction-level model check of memory_arbiter_n with directed and random stimulus
module tb_memory_arbiter_n;
    localparam int N = 4;
    localparam int B = 2;
    localparam logic [1:0] ST_FREE = 2'd0, ST_BUSY = 2'd1, ST_ACCESS = 2'd2, ST_ERROR = 2'd3;
    localparam int K_NONE = 0, K_ARB = 1, K_SNP = 2, K_LOAD = 3, K_COPY = 4, K_WB = 5, K_FETCH = 6;

    logic CLK = 1'b0;
    logic RST;
    logic [N-1:0] iREN, dREN, dWEN, ccwrite, cctrans;
    logic [N-1:0][31:0] iaddr, daddr, dstore;
    logic [N-1:0] iwait, dwait, ccwait, ccinv;
    logic [N-1:0][31:0] iload, dload, ccsnoopaddr;
    logic ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0] ramstate;

    int total = 0;
    int bad = 0;
    int ram_mode = 1;
    bit alt_ph = 1'b0;

    // transaction-level reference: what is being served, for whom, and progress
    int m_kind, m_who, m_sup, m_words, m_dnext, m_inext;

    int log_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] snp_q[$];
    int inv_good, inv_other;

    memory_arbiter_n #(.CPUS(N), .BLKWORDS(B)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .ccwrite(ccwrite), .cctrans(cctrans),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .ccwait(ccwait), .ccinv(ccinv),
        .iload(iload), .dload(dload), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [N-1:0] r, input int ptr);
        for (int off = 0; off < N; off++) begin
            if (r[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    function automatic int lowest_other(input logic [N-1:0] r, input int who);
        for (int k = 0; k < N; k++) begin
            if (k != who && r[k]) return k;
        end
        return -1;
    endfunction

    // reference model advances on each clock using the inputs seen at that edge
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_kind <= K_NONE; m_who <= 0; m_sup <= 0; m_words <= 0; m_dnext <= 0; m_inext <= 0;
        end else begin
            case (m_kind)
                K_NONE: begin
                    if (cctrans != 0) begin
                        m_who <= rr(cctrans, m_dnext); m_kind <= K_ARB;
                    end else if (dWEN != 0) begin
                        m_who <= rr(dWEN, m_dnext); m_kind <= K_WB; m_words <= 0;
                    end else if (iREN != 0) begin
                        m_who <= rr(iREN, m_inext); m_kind <= K_FETCH;
                    end
                end
                K_ARB: m_kind <= dREN[m_who] ? K_SNP : K_NONE;
                K_SNP: begin
                    m_words <= 0;
                    if (lowest_other(cctrans, m_who) >= 0) begin
                        m_sup <= lowest_other(cctrans, m_who); m_kind <= K_COPY;
                    end else begin
                        m_kind <= K_LOAD;
                    end
                end
                K_LOAD, K_COPY, K_WB: begin
                    if (ramstate == ST_ACCESS) begin
                        m_words <= m_words + 1;
                        if (m_words + 1 == B) begin
                            m_kind <= K_NONE; m_dnext <= (m_who + 1) % N;
                        end
                    end
                end
                K_FETCH: begin
                    if (ramstate == ST_ACCESS) begin
                        m_kind <= K_NONE; m_inext <= (m_who + 1) % N;
                    end
                end
                default: m_kind <= K_NONE;
            endcase
        end
    end

    task automatic compare_cycle();
        logic [N-1:0] e_iw, e_dw, e_ccw, e_inv;
        logic [N-1:0][31:0] e_il, e_dl, e_snp;
        logic e_ren, e_wen, acc;
        logic [31:0] e_addr, e_store;
        bit found;
        e_iw = '1; e_dw = '1; e_ccw = '0; e_inv = '0;
        e_il = '0; e_dl = '0; e_snp = '0;
        e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
        acc = (ramstate == ST_ACCESS);
        case (m_kind)
            K_SNP: for (int k = 0; k < N; k++) if (k != m_who) begin
                e_ccw[k] = 1; e_snp[k] = daddr[m_who]; e_inv[k] = ccwrite[m_who];
            end
            K_LOAD: begin
                e_ren = 1; e_addr = daddr[m_who]; e_dl[m_who] = ramload;
                for (int k = 0; k < N; k++) e_ccw[k] = (k != m_who);
                if (acc) e_dw[m_who] = 0;
            end
            K_COPY: begin
                e_dl[m_who] = dstore[m_sup]; e_wen = 1; e_addr = daddr[m_sup];
                e_store = dstore[m_sup]; e_ccw[m_sup] = 1;
                if (acc) begin e_dw[m_who] = 0; e_dw[m_sup] = 0; end
            end
            K_WB: begin
                e_wen = 1; e_addr = daddr[m_who]; e_store = dstore[m_who];
                for (int k = 0; k < N; k++) e_ccw[k] = (k != m_who);
                if (acc) e_dw[m_who] = 0;
            end
            K_FETCH: begin
                e_ren = 1; e_addr = iaddr[m_who]; e_il[m_who] = ramload;
                if (acc) e_iw[m_who] = 0;
            end
            default: ;
        endcase
        chk("iwait", iwait, e_iw);
        chk("dwait", dwait, e_dw);
        chk("ccwait", ccwait, e_ccw);
        chk("ccinv", ccinv, e_inv);
        chk("iload", iload, e_il);
        chk("dload", dload, e_dl);
        chk("ccsnoopaddr", ccsnoopaddr, e_snp);
        chk("ramREN", ramREN, e_ren);
        chk("ramWEN", ramWEN, e_wen);
        chk("ramaddr", ramaddr, e_addr);
        chk("ramstore", ramstore, e_store);
        if (!RST) begin
            found = 0;
            for (int k = 0; k < N; k++) if (!found && !dwait[k]) begin
                found = 1; log_q.push_back((ramREN ? 10 : 20) + k); addr_q.push_back(ramaddr);
            end
            for (int k = 0; k < N; k++) if (!iwait[k]) log_q.push_back(30 + k);
            if (ccsnoopaddr[0] != 0) snp_q.push_back(ccsnoopaddr[0]);
            if (ccinv == 4'b1101) inv_good++;
            else if (ccinv != 0) inv_other++;
        end
    endtask

    always @(negedge CLK) compare_cycle();

    // RAM side: ramstate pattern selected by ram_mode, fresh load data every cycle
    initial begin
        ramstate = ST_FREE;
        ramload  = 0;
        forever begin
            @(posedge CLK); #2;
            ramload = $urandom;
            case (ram_mode)
                0: begin ramstate = alt_ph ? ST_ACCESS : ST_BUSY; alt_ph = ~alt_ph; end
                1: ramstate = ST_ACCESS;
                default: begin
                    int r;
                    r = $urandom_range(0, 9);
                    ramstate = (r < 5) ? ST_ACCESS : (r < 7) ? ST_BUSY : (r < 8) ? ST_ERROR : ST_FREE;
                end
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic clear_inputs();
        iREN = 0; dREN = 0; dWEN = 0; ccwrite = 0; cctrans = 0;
        iaddr = '0; daddr = '0; dstore = '0;
    endtask

    task automatic do_reset();
        RST = 1;
        #1;
        chk("rst_iwait", iwait, 4'hF);
        chk("rst_dwait", dwait, 4'hF);
        chk("rst_ram", {ramREN, ramWEN, ramaddr}, 34'h0);
        @(posedge CLK); #2;
        RST = 0;
    endtask

    function automatic logic [N-1:0] rbits(input int pct);
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = ($urandom_range(0, 99) < pct);
        return v;
    endfunction

    initial begin
        int exp029[5];
        int exp032[5];
        exp029 = '{30, 31, 32, 33, 30};
        exp032 = '{11, 11, 20, 20, 33};
        RST = 1;
        clear_inputs();
        tick(2);
        do_reset();

        // round-robin fetches with ACCESS on alternate cycles
        ram_mode = 0;
        log_q.delete();
        iREN = 4'hF;
        for (int i = 0; i < 4; i++) iaddr[i] = 32'h1000 + 32'(i * 16);
        tick(20);
        iREN = 0;
        tick(4);
        chk("fetch_count", 128'(log_q.size() >= 5), 128'd1);
        for (int i = 0; i < 5; i++) chk($sformatf("fetch_order_%0d", i), 128'(log_q[i]), 128'(exp029[i]));

        // snoop miss: CPU1 loads two words from RAM
        do_reset();
        ram_mode = 1;
        log_q.delete(); addr_q.delete(); snp_q.delete();
        cctrans[1] = 1; dREN[1] = 1; daddr[1] = 32'h100;
        tick(4);
        daddr[1] = 32'h104; cctrans = 0; dREN = 0;
        tick(4);
        chk("ld_log_n", 128'(log_q.size()), 128'd2);
        chk("ld_log0", 128'(log_q[0]), 128'd11);
        chk("ld_addr0", addr_q[0], 32'h100);
        chk("ld_addr1", addr_q[1], 32'h104);
        chk("snoop_n", 128'(snp_q.size()), 128'd1);
        chk("snoop_addr", snp_q[0], 32'h100);

        // cache-to-cache: CPU0 reads 0x200, CPU2 supplies
        do_reset();
        cctrans[0] = 1; dREN[0] = 1; daddr[0] = 32'h200;
        cctrans[2] = 1; daddr[2] = 32'h240; dstore[2] = 32'hCAFE0002;
        tick(3);
        #3;
        chk("cl_dload0", dload[0], 32'hCAFE0002);
        chk("cl_ramwen", ramWEN, 1'b1);
        chk("cl_ramaddr", ramaddr, 32'h240);
        chk("cl_dwait", dwait, 4'b1010);
        chk("cl_ccwait", ccwait, 4'b0100);
        chk("cl_model_src", 128'(m_sup), 128'd2);
        tick(1);
        clear_inputs();
        tick(3);

        // priority: ARB then WB then IF
        do_reset();
        log_q.delete();
        cctrans[1] = 1; dREN[1] = 1; dWEN[0] = 1; iREN[3] = 1;
        daddr[0] = 32'h500; daddr[1] = 32'h600; dstore[0] = 32'h11110000; iaddr[3] = 32'h700;
        tick(4);
        cctrans = 0; dREN = 0;
        tick(3);
        dWEN = 0;
        tick(2);
        iREN = 0;
        tick(3);
        chk("prio_n", 128'(log_q.size()), 128'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("prio_%0d", i), 128'(log_q[i]), 128'(exp032[i]));

        // read-exclusive invalidates the other caches only while snooping
        do_reset();
        clear_inputs();
        inv_good = 0; inv_other = 0;
        cctrans[1] = 1; dREN[1] = 1; ccwrite[1] = 1; daddr[1] = 32'h800;
        tick(4);
        clear_inputs();
        tick(4);
        chk("inv_snoop", 128'(inv_good), 128'd1);
        chk("inv_other", 128'(inv_other), 128'd0);

        // reset during second word of a cache-to-cache copy; dptr returns to 0
        cctrans[2] = 1; dREN[2] = 1; daddr[2] = 32'h300;
        cctrans[3] = 1; daddr[3] = 32'h340; dstore[3] = 32'hD00D0003;
        tick(4);
        #2;
        RST = 1;
        #1;
        chk("rst034_wen", ramWEN, 1'b0);
        chk("rst034_dwait", dwait, 4'hF);
        chk("rst034_ccwait", ccwait, 4'h0);
        chk("rst034_dload", dload, 128'h0);
        clear_inputs();
        tick(1);
        RST = 0;
        dWEN = 4'b1001; daddr[0] = 32'h400; daddr[3] = 32'h440;
        dstore[0] = 32'h5EED0000; dstore[3] = 32'h5EED0003;
        tick(1);
        #3;
        chk("post_rst_store", ramstore, 32'h5EED0000);
        chk("post_rst_addr", ramaddr, 32'h400);
        chk("post_rst_dwait", dwait, 4'b1110);
        tick(1);
        clear_inputs();
        tick(3);

        // randomized traffic with RAM stalls, errors and occasional async reset
        ram_mode = 2;
        for (int c = 0; c < 4000; c++) begin
            tick(1);
            iREN = rbits(30); dREN = rbits(60); dWEN = rbits(15);
            ccwrite = rbits(50); cctrans = rbits(15);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) == 0) iaddr[k] = $urandom;
                if ($urandom_range(0, 3) == 0) daddr[k] = $urandom;
                if ($urandom_range(0, 3) == 0) dstore[k] = $urandom;
            end
            if ($urandom_range(0, 199) == 0) begin
                #2;
                RST = 1;
                @(posedge CLK); #4;
                RST = 0;
            end
        end
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
